// File: rtl/boid_pkg.sv
// rtl/boid_pkg.sv - shared constants and state encoding for the boid display pipeline
// Contents: video geometry, boid count/select width, display address width,
// skip counter width and the frame scheduler state type.
package boid_pkg;

    localparam int VIDEO_WIDTH  = 640;
    localparam int VIDEO_HEIGHT = 480;
    localparam int PIXEL_COUNT  = VIDEO_WIDTH * VIDEO_HEIGHT;
    localparam int MAX_BOIDS    = 4;
    localparam int BOID_BITS    = $clog2(MAX_BOIDS);
    localparam int ADDR_WIDTH   = 19;
    localparam int SKIP_WIDTH   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SEL   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
// Ports:
//   clock    in   system clock
//   reset_n  in   asynchronous active-low reset, clears the count
//   inc      in   increment request; ignored once the count is all ones
//   count    out  current registered count
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/boid_frame_scheduler.sv
// rtl/boid_frame_scheduler.sv - per-frame bank swap, back-bank clear and boid scan sequencer
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   frame_end   in   one-cycle pulse at end of visible frame
//   boid_addr   in   pixel address of the boid currently selected by boid_sel
//   clear_done  in   one-cycle ack: back bank fully cleared
//   boid_sel    out  BPU output mux select
//   clear_req   out  back-bank clear request, held until clear_done
//   disp_we     out  back-bank write enable (write data is constant 1)
//   disp_addr   out  registered back-bank write address
//   front_bank  out  bank read by the VGA side; back bank is ~front_bank
//   busy        out  high from frame accept until DONE
//   overrun     out  sticky: frame_end seen while busy
//   skip_cnt    out  saturating count of off-screen boids skipped
module boid_frame_scheduler
    import boid_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  frame_end,
    input  logic [ADDR_WIDTH-1:0] boid_addr,
    input  logic                  clear_done,
    output logic [BOID_BITS-1:0]  boid_sel,
    output logic                  clear_req,
    output logic                  disp_we,
    output logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  front_bank,
    output logic                  busy,
    output logic                  overrun,
    output logic [SKIP_WIDTH-1:0] skip_cnt
);

    localparam logic [ADDR_WIDTH-1:0] PIX_LIMIT = ADDR_WIDTH'(PIXEL_COUNT);
    localparam logic [BOID_BITS-1:0]  LAST_SEL  = BOID_BITS'(MAX_BOIDS - 1);

    sched_state_t          state_q, state_d;
    logic [BOID_BITS-1:0]  boid_sel_q, boid_sel_d;
    logic                  clear_req_q, clear_req_d;
    logic                  disp_we_q, disp_we_d;
    logic [ADDR_WIDTH-1:0] disp_addr_q, disp_addr_d;
    logic                  front_bank_q, front_bank_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic                  pending_q, pending_d;
    logic                  skip_inc;

    always_comb begin
        state_d      = state_q;
        boid_sel_d   = boid_sel_q;
        clear_req_d  = clear_req_q;
        disp_we_d    = 1'b0;
        disp_addr_d  = disp_addr_q;
        front_bank_d = front_bank_q;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        pending_d    = pending_q;
        skip_inc     = 1'b0;

        // Any frame_end outside IDLE (DONE included) is parked as a single
        // pending frame; extra pulses collapse into the same flag.
        if (frame_end && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_end || pending_q) begin
                    state_d      = ST_CLEAR;
                    front_bank_d = ~front_bank_q;
                    busy_d       = 1'b1;
                    clear_req_d  = 1'b1;
                    pending_d    = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (clear_done) begin
                    clear_req_d = 1'b0;
                    boid_sel_d  = '0;
                    state_d     = ST_SEL;
                end
            end
            ST_SEL: begin
                // Settle cycle so boid_addr reflects the new boid_sel.
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (boid_addr < PIX_LIMIT) begin
                    disp_we_d   = 1'b1;
                    disp_addr_d = boid_addr;
                end else begin
                    skip_inc = 1'b1;
                end
                if (boid_sel_q == LAST_SEL) begin
                    state_d = ST_DONE;
                end else begin
                    boid_sel_d = boid_sel_q + 1'b1;
                    state_d    = ST_SEL;
                end
            end
            ST_DONE: begin
                busy_d     = 1'b0;
                boid_sel_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            boid_sel_q   <= '0;
            clear_req_q  <= 1'b0;
            disp_we_q    <= 1'b0;
            disp_addr_q  <= '0;
            front_bank_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            boid_sel_q   <= boid_sel_d;
            clear_req_q  <= clear_req_d;
            disp_we_q    <= disp_we_d;
            disp_addr_q  <= disp_addr_d;
            front_bank_q <= front_bank_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            pending_q    <= pending_d;
        end
    end

    sat_counter #(
        .WIDTH (SKIP_WIDTH)
    ) u_skip_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (skip_inc),
        .count   (skip_cnt)
    );

    assign boid_sel   = boid_sel_q;
    assign clear_req  = clear_req_q;
    assign disp_we    = disp_we_q;
    assign disp_addr  = disp_addr_q;
    assign front_bank = front_bank_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
